// File: rtl/uart_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_apb_ctrl
// Description : APB slave controller for the UART datapath. Holds one RX byte
//               taken from the RX buffer and one TX byte offered to the
//               transmitter. Exports baud divisor and enables, and raises a
//               level interrupt. Blocked DATA writes insert wait states up to
//               TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_apb_ctrl #(
    parameter logic [15:0] BAUD_RST = 16'd868,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rstn,
    // APB slave
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    // RX buffer side
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    // TX side
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    // Configuration and interrupt
    output logic [15:0] baud_div_o,
    output logic        rx_en_o,
    output logic        tx_en_o,
    output logic        irq_o
);

    // APB sequencing states
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;

    // Register offsets (paddr[3:2])
    localparam logic [1:0] c_addr_data   = 2'd0;
    localparam logic [1:0] c_addr_status = 2'd1;
    localparam logic [1:0] c_addr_ctrl   = 2'd2;
    localparam logic [1:0] c_addr_baud   = 2'd3;

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    logic [1:0]  r_state;
    logic [15:0] r_wait_cnt;
    logic        r_rx_full;
    logic [7:0]  r_rx_data;
    logic        r_tx_full;
    logic [7:0]  r_tx_data;
    logic [15:0] r_baud;
    logic        r_rx_en;
    logic        r_tx_en;
    logic        r_ie_rx;
    logic        r_ie_tx;
    logic        r_err;
    logic        r_irq;

    logic        w_acc;
    logic        w_is_data;
    logic        w_is_status;
    logic        w_is_ctrl;
    logic        w_is_baud;
    logic        w_tx_blocked;
    logic        w_pready;
    logic        w_wr;
    logic        w_rd;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic        w_rd_empty;
    logic        w_baud_zero;
    logic        w_baud_load;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic        w_err_clr;
    logic        w_err_set;
    logic        w_rx_cap;
    logic        w_tx_drain;
    logic        w_pslverr;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Upper write-data bits and the byte-lane address bits carry no meaning
    assign w_unused = ^{pwdata[31:16], paddr[1:0]};

    // Address decode
    assign w_is_data   = (paddr[3:2] == c_addr_data);
    assign w_is_status = (paddr[3:2] == c_addr_status);
    assign w_is_ctrl   = (paddr[3:2] == c_addr_ctrl);
    assign w_is_baud   = (paddr[3:2] == c_addr_baud);

    // A live access phase: FSM in ACCESS with the bus still asserting it
    assign w_acc        = (r_state == c_st_access) & psel & penable;
    // DATA write against a full TX holding register must wait
    assign w_tx_blocked = pwrite & w_is_data & r_tx_full;
    // Complete immediately unless blocked; a blocked write gives up at TIMEOUT
    assign w_pready     = w_acc & (~w_tx_blocked | (r_wait_cnt == c_timeout));

    // Side effects are qualified by the completing cycle
    assign w_wr        = w_pready & pwrite;
    assign w_rd        = w_pready & ~pwrite;
    assign w_push      = w_wr & w_is_data & ~r_tx_full;
    assign w_drop      = w_wr & w_is_data & r_tx_full;
    assign w_pop       = w_rd & w_is_data & r_rx_full;
    assign w_rd_empty  = w_rd & w_is_data & ~r_rx_full;
    assign w_baud_zero = w_wr & w_is_baud & (pwdata[15:0] == 16'd0);
    assign w_baud_load = w_wr & w_is_baud & (pwdata[15:0] != 16'd0);
    assign w_ctrl_wr   = w_wr & w_is_ctrl;
    assign w_flush     = w_ctrl_wr & pwdata[4];
    assign w_err_clr   = w_wr & w_is_status & pwdata[2];
    assign w_err_set   = w_drop | w_rd_empty;
    assign w_pslverr   = w_drop | w_rd_empty | w_baud_zero;

    // Datapath handshakes
    assign rx_ready_o = r_rx_en & ~r_rx_full;
    assign tx_valid_o = r_tx_full & r_tx_en;
    assign w_rx_cap   = rx_valid_i & rx_ready_o;
    assign w_tx_drain = tx_valid_o & tx_ready_i;

    // Read mux; flush always reads back as 0 and unused bits are 0
    always_comb begin
        w_rdata = 32'd0;
        case (paddr[3:2])
            c_addr_data:   w_rdata = r_rx_full ? {24'd0, r_rx_data} : 32'd0;
            c_addr_status: w_rdata = {29'd0, r_err, r_tx_full, r_rx_full};
            c_addr_ctrl:   w_rdata = {28'd0, r_ie_tx, r_ie_rx, r_tx_en, r_rx_en};
            c_addr_baud:   w_rdata = {16'd0, r_baud};
            default:       w_rdata = 32'd0;
        endcase
    end

    // Response outputs are derived from registered state so an async reset
    // forces them to zero in the same cycle
    assign pready  = w_pready;
    assign pslverr = w_pslverr;
    assign prdata  = (w_pready & ~pwrite) ? w_rdata : 32'd0;

    assign tx_data_o  = r_tx_data;
    assign baud_div_o = r_baud;
    assign rx_en_o    = r_rx_en;
    assign tx_en_o    = r_tx_en;
    assign irq_o      = r_irq;

    // APB phase tracking; any loss of psel/penable abandons the transfer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:   if (psel & ~penable) r_state <= c_st_setup;
                c_st_setup: begin
                    if (!psel)        r_state <= c_st_idle;
                    else if (penable) r_state <= c_st_access;
                end
                c_st_access: if (!w_acc || w_pready) r_state <= c_st_idle;
                default:     r_state <= c_st_idle;
            endcase
        end
    end

    // Wait-state counter: counts stalled access cycles, cleared otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_wait_cnt <= 16'd0;
        else if (w_acc && !w_pready) r_wait_cnt <= r_wait_cnt + 16'd1;
        else r_wait_cnt <= 16'd0;
    end

    // RX holding register; flush wins over a same-edge capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_full <= 1'b0;
            r_rx_data <= 8'd0;
        end else if (w_flush) begin
            r_rx_full <= 1'b0;
        end else if (w_rx_cap) begin
            r_rx_full <= 1'b1;
            r_rx_data <= rx_data_i;
        end else if (w_pop) begin
            r_rx_full <= 1'b0;
        end
    end

    // TX holding register; a push only happens when empty, so it never
    // coincides with a drain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_full <= 1'b0;
            r_tx_data <= 8'd0;
        end else if (w_flush) begin
            r_tx_full <= 1'b0;
        end else if (w_push) begin
            r_tx_full <= 1'b1;
            r_tx_data <= pwdata[7:0];
        end else if (w_tx_drain) begin
            r_tx_full <= 1'b0;
        end
    end

    // Control and baud configuration registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_baud  <= BAUD_RST;
            r_rx_en <= 1'b0;
            r_tx_en <= 1'b0;
            r_ie_rx <= 1'b0;
            r_ie_tx <= 1'b0;
        end else begin
            if (w_baud_load) r_baud <= pwdata[15:0];
            if (w_ctrl_wr) begin
                r_rx_en <= pwdata[0];
                r_tx_en <= pwdata[1];
                r_ie_rx <= pwdata[2];
                r_ie_tx <= pwdata[3];
            end
        end
    end

    // Sticky error flag, write-1-to-clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
        else if (w_err_clr) r_err <= 1'b0;
    end

    // Registered interrupt, one cycle behind the holding-register state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_irq <= 1'b0;
        else r_irq <= (r_ie_rx & r_rx_full) | (r_ie_tx & ~r_tx_full);
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_apb_ctrl
// Description : Directed self-checking bench for uart_apb_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_apb_ctrl;

    localparam int unsigned c_timeout = 8;

    logic        clk;
    logic        rstn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [15:0] baud_div_o;
    logic        rx_en_o;
    logic        tx_en_o;
    logic        irq_o;

    int          checks;
    int          failures;
    logic [31:0] rv;
    logic        er;
    int          wt;

    uart_apb_ctrl #(
        .BAUD_RST (16'd868),
        .TIMEOUT  (c_timeout)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .baud_div_o (baud_div_o),
        .rx_en_o    (rx_en_o),
        .tx_en_o    (tx_en_o),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One APB transfer; returns read data, error and number of stalled cycles
    task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int waits);
        bit done;
        rdata = 32'd0;
        err   = 1'b0;
        waits = 0;
        done  = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 200 && !done; n++) begin
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                done  = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!done) check("apb_hang", 32'd0, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 4'h0; pwdata = 32'd0;
        rx_data_i = 8'd0; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", rx_ready_o, 1'b0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_baud", baud_div_o, 16'd868);
        check("rst_tx_valid", tx_valid_o, 1'b0);
        check("rst_pready", pready, 1'b0);
        rstn = 1'b1;

        // 1: reset readback
        apb(1'b0, 4'hC, 32'd0, rv, er, wt);
        check("t1_baud", rv, 32'd868);
        apb(1'b0, 4'h8, 32'd0, rv, er, wt);
        check("t1_ctrl", rv, 32'd0);

        // 2: RX capture and pop
        apb(1'b1, 4'h8, 32'h05, rv, er, wt);
        check("t2_ctrl_err", er, 1'b0);
        check("t2_rx_ready", rx_ready_o, 1'b1);
        rx_data_i = 8'hA5; rx_valid_i = 1'b1;
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
        check("t2_rx_ready_drop", rx_ready_o, 1'b0);
        @(posedge clk); #1;
        check("t2_irq", irq_o, 1'b1);
        apb(1'b0, 4'h4, 32'd0, rv, er, wt);
        check("t2_status_full", rv, 32'h1);
        apb(1'b0, 4'h0, 32'd0, rv, er, wt);
        check("t2_data", rv, 32'hA5);
        check("t2_data_err", er, 1'b0);
        apb(1'b0, 4'h4, 32'd0, rv, er, wt);
        check("t2_status_empty", rv, 32'h0);
        check("t2_rx_ready_back", rx_ready_o, 1'b1);
        check("t2_irq_off", irq_o, 1'b0);

        // 3: TX push, stall, drain, completion
        apb(1'b1, 4'h8, 32'h07, rv, er, wt);
        apb(1'b1, 4'h0, 32'h3C, rv, er, wt);
        check("t3_push_waits", wt, 0);
        check("t3_tx_valid", tx_valid_o, 1'b1);
        check("t3_tx_data", tx_data_o, 8'h3C);
        fork
            apb(1'b1, 4'h0, 32'h55, rv, er, wt);
            begin
                repeat (5) @(posedge clk);
                #1 tx_ready_i = 1'b1;
                @(posedge clk);
                #1 tx_ready_i = 1'b0;
            end
        join
        check("t3_stalled", (wt > 0), 1'b1);
        check("t3_err", er, 1'b0);
        check("t3_tx_data2", tx_data_o, 8'h55);
        check("t3_tx_valid2", tx_valid_o, 1'b1);

        // 4: blocked write times out
        apb(1'b1, 4'h0, 32'h77, rv, er, wt);
        check("t4_waits", wt, c_timeout);
        check("t4_err", er, 1'b1);
        check("t4_tx_kept", tx_data_o, 8'h55);
        apb(1'b0, 4'h4, 32'd0, rv, er, wt);
        check("t4_status", rv, 32'h6);
        apb(1'b1, 4'h4, 32'h4, rv, er, wt);
        apb(1'b0, 4'h4, 32'd0, rv, er, wt);
        check("t4_status_w1c", rv, 32'h2);

        // 5: read with RX empty, zero baud write
        apb(1'b0, 4'h0, 32'd0, rv, er, wt);
        check("t5_rd_empty_data", rv, 32'h0);
        check("t5_rd_empty_err", er, 1'b1);
        apb(1'b1, 4'h4, 32'h4, rv, er, wt);
        apb(1'b1, 4'hC, 32'h0, rv, er, wt);
        check("t5_baud0_err", er, 1'b1);
        check("t5_baud0_kept", baud_div_o, 16'd868);
        apb(1'b0, 4'h4, 32'd0, rv, er, wt);
        check("t5_status_no_err", rv, 32'h2);
        apb(1'b1, 4'hC, 32'h1234, rv, er, wt);
        check("t5_baud_err", er, 1'b0);
        check("t5_baud", baud_div_o, 16'h1234);

        // 6: flush with both holding registers full
        rx_data_i = 8'h5A; rx_valid_i = 1'b1;
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
        apb(1'b0, 4'h4, 32'd0, rv, er, wt);
        check("t6_status_full", rv, 32'h3);
        apb(1'b1, 4'h8, 32'h1F, rv, er, wt);
        apb(1'b0, 4'h4, 32'd0, rv, er, wt);
        check("t6_status_flushed", rv, 32'h0);
        apb(1'b0, 4'h8, 32'd0, rv, er, wt);
        check("t6_ctrl", rv, 32'h0F);
        check("t6_irq", irq_o, 1'b1);

        // 6b: async reset in the middle of a wait
        apb(1'b1, 4'h0, 32'h11, rv, er, wt);
        check("t6_tx_data", tx_data_o, 8'h11);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h22;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_wait", pready, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check("t6r_pready", pready, 1'b0);
        check("t6r_tx_valid", tx_valid_o, 1'b0);
        check("t6r_tx_data", tx_data_o, 8'h00);
        check("t6r_baud", baud_div_o, 16'd868);
        check("t6r_rx_ready", rx_ready_o, 1'b0);
        check("t6r_en", {rx_en_o, tx_en_o}, 2'b00);
        check("t6r_prdata", prdata, 32'd0);
        check("t6r_pslverr", pslverr, 1'b0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        apb(1'b0, 4'h4, 32'd0, rv, er, wt);
        check("t6r_status", rv, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
